// File: rtl/smem_pkg.sv
// smem_pkg: shared constants and types for the shared-memory bank arbiter.
//   NUM_BANKS    - number of shared-memory banks (4-bit bank select)
//   BANK_SEL_W   - width of the bank-select field, taken from addr[3:0]
//   LOCAL_ADDR_W - width of the bank-local address, taken from addr[11:4]
//   DATA_W       - bank data width
//   ID_W         - requester id width, enough for up to 8 requesters
//   inflight_t   - per-bank record of the request that was issued last cycle
package smem_pkg;

  localparam int NUM_BANKS    = 16;
  localparam int BANK_SEL_W   = 4;
  localparam int LOCAL_ADDR_W = 8;
  localparam int DATA_W       = 8;
  localparam int ID_W         = 3;

  typedef struct packed {
    logic            valid;
    logic [ID_W-1:0] id;
    logic            write;
  } inflight_t;

endpackage

// File: rtl/smem_rr_arbiter.sv
// smem_rr_arbiter: round-robin arbiter for a single bank.
//   clock - system clock, rising edge
//   reset - synchronous active-low reset; the pointer returns to 0
//   req   - NUM_REQ-wide request vector
//   gnt   - one-hot grant; the winner is the first requester at or after
//           the pointer, scanning upward modulo NUM_REQ
// On a grant the pointer advances to winner+1 (wrapping); otherwise it holds.
module smem_rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic             found;

  always_comb begin
    gnt   = '0;
    ptr_d = ptr_q;
    found = 1'b0;
    // k is the distance from the pointer; the first requesting slot wins.
    for (int k = 0; k < NUM_REQ; k++) begin
      for (int j = 0; j < NUM_REQ; j++) begin
        if (!found && req[j] && (j == (int'(ptr_q) + k) % NUM_REQ)) begin
          found  = 1'b1;
          gnt[j] = 1'b1;
          ptr_d  = (j == NUM_REQ - 1) ? '0 : PTR_W'(j + 1);
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) ptr_q <= '0;
    else        ptr_q <= ptr_d;
  end

endmodule

// File: rtl/smem_bank_arbiter.sv
// smem_bank_arbiter: shares the shared-memory banks among NUM_REQ requesters.
// Each request address is split into bank = addr[3:0] and local = addr[11:4];
// every bank runs its own round-robin arbiter. The winner drives the bank
// pins in the accept cycle, the bank answers one cycle later, and the
// response is registered so resp_valid appears exactly two cycles after
// acceptance.
//   clock, reset   - system clock; synchronous active-low reset
//   req_*          - per-requester valid/write/addr/wdata, ready is combinational
//   resp_valid/rdata - registered responses (rdata is 0 for write acks)
//   bank_*         - per-bank read/write strobes, local address, write data,
//                    returned read data and completion flag
//   conflict_count - only when SMEM_CONFLICT_CNT_EN is defined: saturating
//                    count of cycles in which a valid request was denied
module smem_bank_arbiter
  import smem_pkg::*;
#(
  parameter int NUM_REQ   = 4,
  parameter int NUM_BANKS = smem_pkg::NUM_BANKS,
  parameter int ADDR_W    = 12,
  parameter int DATA_W    = smem_pkg::DATA_W
) (
  input  logic                           clock,
  input  logic                           reset,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_write,
  input  logic [NUM_REQ*ADDR_W-1:0]      req_addr,
  input  logic [NUM_REQ*DATA_W-1:0]      req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic [NUM_REQ-1:0]             resp_valid,
  output logic [NUM_REQ*DATA_W-1:0]      resp_rdata,
  output logic [NUM_BANKS-1:0]           bank_read,
  output logic [NUM_BANKS-1:0]           bank_write,
  output logic [NUM_BANKS*LOCAL_ADDR_W-1:0] bank_addr,
  output logic [NUM_BANKS*DATA_W-1:0]    bank_wdata,
  input  logic [NUM_BANKS*DATA_W-1:0]    bank_rdata,
  input  logic [NUM_BANKS-1:0]           bank_finish
`ifdef SMEM_CONFLICT_CNT_EN
  ,
  output logic [15:0]                    conflict_count
`endif
);

  logic [NUM_BANKS-1:0][NUM_REQ-1:0] cand;
  logic [NUM_BANKS-1:0][NUM_REQ-1:0] gnt;
  inflight_t [NUM_BANKS-1:0]         infl_q, infl_d;
  logic [NUM_REQ-1:0]                resp_valid_q, resp_valid_d;
  logic [NUM_REQ*DATA_W-1:0]         resp_rdata_q, resp_rdata_d;

  // Banks always complete in one cycle, so the completion flag carries no
  // extra information; responses are issued from the in-flight record alone.
  logic unused_finish;
  assign unused_finish = ^bank_finish;

  // Requests are masked during reset so no grant or strobe can escape.
  always_comb begin
    cand = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        cand[b][i] = reset & req_valid[i] &
                     (req_addr[i*ADDR_W +: BANK_SEL_W] == BANK_SEL_W'(b));
      end
    end
  end

  for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
    smem_rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
      .clock (clock),
      .reset (reset),
      .req   (cand[b]),
      .gnt   (gnt[b])
    );
  end

  // Grants are one-hot per bank and each requester targets one bank, so
  // the winner's fields can simply be steered onto the bank pins.
  always_comb begin
    req_ready  = '0;
    bank_read  = '0;
    bank_write = '0;
    bank_addr  = '0;
    bank_wdata = '0;
    infl_d     = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (gnt[b][i]) begin
          req_ready[i]  = 1'b1;
          bank_read[b]  = ~req_write[i];
          bank_write[b] = req_write[i];
          bank_addr[b*LOCAL_ADDR_W +: LOCAL_ADDR_W] =
            req_addr[i*ADDR_W + BANK_SEL_W +: LOCAL_ADDR_W];
          bank_wdata[b*DATA_W +: DATA_W] = req_wdata[i*DATA_W +: DATA_W];
          infl_d[b].valid = 1'b1;
          infl_d[b].id    = ID_W'(i);
          infl_d[b].write = req_write[i];
        end
      end
    end
  end

  // A requester owns at most one in-flight entry per cycle, so at most one
  // bank matches each response slot.
  always_comb begin
    resp_valid_d = '0;
    resp_rdata_d = '0;
    for (int b = 0; b < NUM_BANKS; b++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (infl_q[b].valid && (infl_q[b].id == ID_W'(i))) begin
          resp_valid_d[i] = 1'b1;
          resp_rdata_d[i*DATA_W +: DATA_W] =
            infl_q[b].write ? '0 : bank_rdata[b*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      infl_q       <= '0;
      resp_valid_q <= '0;
      resp_rdata_q <= '0;
    end else begin
      infl_q       <= infl_d;
      resp_valid_q <= resp_valid_d;
      resp_rdata_q <= resp_rdata_d;
    end
  end

  assign resp_valid = resp_valid_q;
  assign resp_rdata = resp_rdata_q;

`ifdef SMEM_CONFLICT_CNT_EN
  logic [15:0] conflict_count_q, conflict_count_d;
  logic        denied;

  // Every denial of a valid request is a lost bank conflict.
  always_comb begin
    denied           = reset & (|(req_valid & ~req_ready));
    conflict_count_d = conflict_count_q;
    if (denied && (conflict_count_q != 16'hFFFF))
      conflict_count_d = conflict_count_q + 16'd1;
  end

  always_ff @(posedge clock) begin
    if (!reset) conflict_count_q <= '0;
    else        conflict_count_q <= conflict_count_d;
  end

  assign conflict_count = conflict_count_q;
`endif

endmodule
